// File: rtl/sdf_butterfly_stage.sv
// Radix-2 single-path delay-feedback butterfly/control stage.
// Drives and consumes an external DelayBuffer of depth DEPTH, forms saturated
// sum/difference pairs and merges sums and drained differences into one
// registered output stream for the downstream twiddle multiplier.
// Optional build macro: SDF_BF_SCALE_EN (scale sum/diff by 1/2, round half up).

`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif

module sdf_butterfly_stage #(
  parameter int DEPTH = 8,
  parameter int W     = `DATA_IN_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       di_en,
  input  logic [W-1:0]               di_re,
  input  logic [W-1:0]               di_im,
  output logic                       db_di_en,
  output logic [W-1:0]               db_di_re,
  output logic [W-1:0]               db_di_im,
  input  logic                       db_do_en,
  input  logic [W-1:0]               db_do_re,
  input  logic [W-1:0]               db_do_im,
  output logic                       do_en,
  output logic [W-1:0]               do_re,
  output logic [W-1:0]               do_im,
  output logic                       do_tw,
  output logic [$clog2(DEPTH)-1:0]   do_idx,
  output logic                       err_gap
);

  localparam int CW = $clog2(2 * DEPTH);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = $clog2(DEPTH) + 1;

  localparam logic [SW-1:0]         SUPP_INIT = SW'(DEPTH);
  localparam logic signed [W+1:0]   SAT_MAX   = $signed({3'b000, {(W-1){1'b1}}});
  localparam logic signed [W+1:0]   SAT_MIN   = $signed({3'b111, {(W-1){1'b0}}});
`ifdef SDF_BF_SCALE_EN
  localparam logic signed [W+1:0]   RND_ONE   = $signed({{(W+1){1'b0}}, 1'b1});
`endif

  // Widen, add or subtract, optionally halve, then clamp to the W-bit range.
  function automatic logic [W-1:0] bf_op(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic         sub);
    logic signed [W+1:0] ax;
    logic signed [W+1:0] bx;
    logic signed [W+1:0] x;
    ax = $signed({{2{a[W-1]}}, a});
    bx = $signed({{2{b[W-1]}}, b});
    x  = sub ? (ax - bx) : (ax + bx);
`ifdef SDF_BF_SCALE_EN
    x  = (x + RND_ONE) >>> 1;
`endif
    if (x > SAT_MAX)      bf_op = SAT_MAX[W-1:0];
    else if (x < SAT_MIN) bf_op = SAT_MIN[W-1:0];
    else                  bf_op = x[W-1:0];
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] drain_idx_q, drain_idx_d;
  logic [SW-1:0] supp_q, supp_d;
  logic          do_en_q, do_en_d;
  logic [W-1:0]  do_re_q, do_re_d;
  logic [W-1:0]  do_im_q, do_im_d;
  logic          do_tw_q, do_tw_d;
  logic [IW-1:0] do_idx_q, do_idx_d;
  logic          err_gap_q, err_gap_d;

  logic          bf_fire, gap, drain_fire;
  logic [W-1:0]  sum_re, sum_im, dif_re, dif_im;

  // Cycle classification and butterfly arithmetic (a = delayed sample, b = new sample).
  always_comb begin
    bf_fire    = cnt_q[CW-1] & di_en;
    gap        = ~di_en & (cnt_q != '0);
    // Drain yields to the butterfly, is killed by a gap, and waits out supp.
    drain_fire = ~bf_fire & ~gap & db_do_en & (supp_q == '0);
    sum_re     = bf_op(db_do_re, di_re, 1'b0);
    sum_im     = bf_op(db_do_im, di_im, 1'b0);
    dif_re     = bf_op(db_do_re, di_re, 1'b1);
    dif_im     = bf_op(db_do_im, di_im, 1'b1);
  end

  // DelayBuffer feed: raw input during fill, difference during butterfly.
  always_comb begin
    db_di_en = di_en;
    db_di_re = bf_fire ? dif_re : di_re;
    db_di_im = bf_fire ? dif_im : di_im;
  end

  // Next-state for counters, suppression window and the output register.
  always_comb begin
    cnt_d       = di_en ? cnt_q + 1'b1 : '0;
    drain_idx_d = drain_idx_q;
    supp_d      = supp_q;
    do_en_d     = bf_fire | drain_fire;
    do_re_d     = do_re_q;
    do_im_d     = do_im_q;
    do_tw_d     = do_tw_q;
    do_idx_d    = do_idx_q;
    err_gap_d   = gap;

    if (gap) begin
      drain_idx_d = '0;
      supp_d      = SUPP_INIT;
    end else begin
      if (supp_q != '0) supp_d = supp_q - 1'b1;
      if (drain_fire)   drain_idx_d = drain_idx_q + 1'b1;
    end

    if (bf_fire) begin
      do_re_d  = sum_re;
      do_im_d  = sum_im;
      do_tw_d  = 1'b0;
      do_idx_d = '0;
    end else if (drain_fire) begin
      do_re_d  = db_do_re;
      do_im_d  = db_do_im;
      do_tw_d  = 1'b1;
      do_idx_d = drain_idx_q;
    end
  end

  // State registers; supp starts full because the delay line is unflushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      drain_idx_q <= '0;
      supp_q      <= SUPP_INIT;
      do_en_q     <= 1'b0;
      do_re_q     <= '0;
      do_im_q     <= '0;
      do_tw_q     <= 1'b0;
      do_idx_q    <= '0;
      err_gap_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      drain_idx_q <= drain_idx_d;
      supp_q      <= supp_d;
      do_en_q     <= do_en_d;
      do_re_q     <= do_re_d;
      do_im_q     <= do_im_d;
      do_tw_q     <= do_tw_d;
      do_idx_q    <= do_idx_d;
      err_gap_q   <= err_gap_d;
    end
  end

  // Output port mapping.
  always_comb begin
    do_en   = do_en_q;
    do_re   = do_re_q;
    do_im   = do_im_q;
    do_tw   = do_tw_q;
    do_idx  = do_idx_q;
    err_gap = err_gap_q;
  end

endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// Bench for sdf_butterfly_stage (DEPTH=4, W=16) with a behavioural DelayBuffer.
// Expected outputs come from a frame-level model: each frame's sample pairs
// (x[k], x[k+DEPTH]) give a sum one cycle later and a difference DEPTH cycles
// after that; a gap or reset cancels every pending difference.
// Honors SDF_BF_SCALE_EN the same way as the design.

module tb_sdf_butterfly_stage;

  localparam int D    = 4;
  localparam int W    = 16;
  localparam int MAXC = 4096;
  localparam int SMAX = (1 <<< (W - 1)) - 1;
  localparam int SMIN = -(1 <<< (W - 1));

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  di_en;
  logic [W-1:0]          di_re, di_im;
  logic                  db_di_en;
  logic [W-1:0]          db_di_re, db_di_im;
  logic                  db_do_en;
  logic [W-1:0]          db_do_re, db_do_im;
  logic                  do_en;
  logic [W-1:0]          do_re, do_im;
  logic                  do_tw;
  logic [$clog2(D)-1:0]  do_idx;
  logic                  err_gap;

  sdf_butterfly_stage #(.DEPTH(D), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .di_en    (di_en),
    .di_re    (di_re),
    .di_im    (di_im),
    .db_di_en (db_di_en),
    .db_di_re (db_di_re),
    .db_di_im (db_di_im),
    .db_do_en (db_do_en),
    .db_do_re (db_do_re),
    .db_do_im (db_do_im),
    .do_en    (do_en),
    .do_re    (do_re),
    .do_im    (do_im),
    .do_tw    (do_tw),
    .do_idx   (do_idx),
    .err_gap  (err_gap)
  );

  always #5 clk = ~clk;

  // External DelayBuffer: shifts every clock, no reset; preload fills it with
  // stale valid garbage.
  logic          preload;
  logic          be [D];
  logic [W-1:0]  br [D];
  logic [W-1:0]  bi [D];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < D; i++) begin
        be[i] <= 1'b1;
        br[i] <= W'($urandom);
        bi[i] <= W'($urandom);
      end
    end else begin
      be[0] <= db_di_en;
      br[0] <= db_di_re;
      bi[0] <= db_di_im;
      for (int i = 1; i < D; i++) begin
        be[i] <= be[i-1];
        br[i] <= br[i-1];
        bi[i] <= bi[i-1];
      end
    end
  end

  assign db_do_en = be[D-1];
  assign db_do_re = br[D-1];
  assign db_do_im = bi[D-1];

  // Reference model state.
  int nvec = 0;
  int nerr = 0;
  int t;
  int cnt_m;
  int xr [2*D];
  int xi [2*D];
  bit s_en  [MAXC];
  int s_re  [MAXC];
  int s_im  [MAXC];
  bit s_tw  [MAXC];
  int s_idx [MAXC];
  bit s_err [MAXC];
  int e_re, e_im, e_idx;
  bit e_tw;

  function automatic int bfop(input int a, input int b, input bit sub);
    int x;
    x = sub ? (a - b) : (a + b);
`ifdef SDF_BF_SCALE_EN
    x = (x + 1) >>> 1;
`endif
    if (x > SMAX) x = SMAX;
    if (x < SMIN) x = SMIN;
    return x;
  endfunction

  function automatic logic [31:0] uw(input int v);
    logic [W-1:0] r;
    r = v[W-1:0];
    return {{(32-W){1'b0}}, r};
  endfunction

  function automatic int rv();
    case ($urandom_range(0, 5))
      0:       return SMAX;
      1:       return SMIN;
      default: return int'($urandom_range(0, (1 << W) - 1)) + SMIN;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      s_en[c]  = 1'b0;
      s_err[c] = 1'b0;
    end
  endtask

  // One cycle: check registered outputs, drive inputs, check buffer feed, update model.
  task automatic step(input bit en, input int re, input int im);
    int k, ar, ai, er, ei;
    if (s_en[t]) begin
      e_re  = s_re[t];
      e_im  = s_im[t];
      e_tw  = s_tw[t];
      e_idx = s_idx[t];
    end
    check("do_en",   32'(do_en),   32'(s_en[t]));
    check("do_re",   32'(do_re),   uw(e_re));
    check("do_im",   32'(do_im),   uw(e_im));
    check("do_tw",   32'(do_tw),   32'(e_tw));
    check("do_idx",  32'(do_idx),  32'(e_idx));
    check("err_gap", 32'(err_gap), 32'(s_err[t]));

    di_en = en;
    di_re = re[W-1:0];
    di_im = im[W-1:0];
    #1;
    if (en) begin
      k  = cnt_m;
      er = re;
      ei = im;
      if (k >= D) begin
        ar = xr[k-D];
        ai = xi[k-D];
        s_en[t+1]    = 1'b1;
        s_re[t+1]    = bfop(ar, re, 1'b0);
        s_im[t+1]    = bfop(ai, im, 1'b0);
        s_tw[t+1]    = 1'b0;
        s_idx[t+1]   = 0;
        er = bfop(ar, re, 1'b1);
        ei = bfop(ai, im, 1'b1);
        s_en[t+1+D]  = 1'b1;
        s_re[t+1+D]  = er;
        s_im[t+1+D]  = ei;
        s_tw[t+1+D]  = 1'b1;
        s_idx[t+1+D] = k - D;
      end
      xr[k] = re;
      xi[k] = im;
      check("db_di_en", 32'(db_di_en), 32'd1);
      check("db_di_re", 32'(db_di_re), uw(er));
      check("db_di_im", 32'(db_di_im), uw(ei));
      cnt_m = (k + 1) % (2 * D);
    end else begin
      check("db_di_en", 32'(db_di_en), 32'd0);
      if (cnt_m != 0) begin
        clear_from(t + 1);
        s_err[t+1] = 1'b1;
        cnt_m = 0;
      end
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_do_en"},   32'(do_en),   32'd0);
    check({tag, "_do_re"},   32'(do_re),   32'd0);
    check({tag, "_do_im"},   32'(do_im),   32'd0);
    check({tag, "_do_tw"},   32'(do_tw),   32'd0);
    check({tag, "_do_idx"},  32'(do_idx),  32'd0);
    check({tag, "_err_gap"}, 32'(err_gap), 32'd0);
  endtask

  // Asynchronous reset asserted between clock edges, released one cycle later.
  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    di_en = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cnt_m = 0;
    e_re  = 0;
    e_im  = 0;
    e_tw  = 1'b0;
    e_idx = 0;
    clear_from(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, nidle;
    rst_n   = 1'b0;
    di_en   = 1'b0;
    di_re   = '0;
    di_im   = '0;
    preload = 1'b1;
    t       = 0;
    cnt_m   = 0;
    e_re    = 0;
    e_im    = 0;
    e_tw    = 1'b0;
    e_idx   = 0;
    clear_from(0);
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    preload = 1'b0;
    rst_n   = 1'b1;

    // Single frame 1..8.
    for (int i = 1; i <= 2 * D; i++) step(1'b1, i, 0);
    idle(3 * D);

    // Two back-to-back frames.
    for (int i = 1; i <= 2 * D; i++) step(1'b1, i, 0);
    for (int i = 11; i <= 10 + 2 * D; i++) step(1'b1, i, 0);
    idle(3 * D);

    // Saturation and rounding corners on re and im.
    for (int i = 0; i < D; i++) step(1'b1, SMAX, SMIN);
    for (int i = 0; i < D; i++) step(1'b1, SMAX, SMAX);
    for (int i = 0; i < D; i++) step(1'b1, SMAX, 3);
    for (int i = 0; i < D; i++) step(1'b1, SMIN, 4);
    idle(3 * D);

    // Gap at cnt=6, fresh frame on the very next cycle.
    for (int i = 1; i <= 6; i++) step(1'b1, i * 100, -i);
    step(1'b0, 0, 0);
    for (int i = 1; i <= 2 * D; i++) step(1'b1, i, 2 * i);
    idle(3 * D);

    // Reset in the middle of the butterfly phase, then a cold-start frame.
    for (int i = 1; i <= D + 2; i++) step(1'b1, i * 7, i);
    mid_reset();
    for (int i = 1; i <= 2 * D; i++) step(1'b1, -i, i * 3);
    idle(3 * D);

    // Random frames: mostly complete, some cut short, mixed idle spacing.
    for (int f = 0; f < 80; f++) begin
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2 * D - 1)) : 2 * D;
      for (int i = 0; i < len; i++) step(1'b1, rv(), rv());
      if (len < 2 * D) step(1'b0, 0, 0);
      nidle = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      idle(nidle);
    end
    idle(3 * D + 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
